// File: rtl/wb_regfile_stage_if.sv
// -----------------------------------------------------------------------------
// wb_regfile_stage_if
//   Groups the signals between the MEM/WB register / ID stage and the
//   write-back register-file stage.
//   master : pipeline side. Drives the MEM/WB outputs and the ID read addresses,
//            and receives the read data, forwarding info, WWD port and counter.
//   slave  : the wb_regfile_stage itself.
// Signals
//   wb_valid, mem_data, alu_result, rd, mem_to_reg, reg_write, is_wwd  (to stage)
//   rs1_addr, rs2_addr                                                 (to stage)
//   rs1_data, rs2_data, wb_data, wb_fwd_en, wb_fwd_rd                  (from stage)
//   output_port, num_inst                                              (from stage)
// -----------------------------------------------------------------------------
interface wb_regfile_stage_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 2
);
  logic                 wb_valid;
  logic [WORD_SIZE-1:0] mem_data;
  logic [WORD_SIZE-1:0] alu_result;
  logic [ADDR_W-1:0]    rd;
  logic                 mem_to_reg;
  logic                 reg_write;
  logic                 is_wwd;
  logic [ADDR_W-1:0]    rs1_addr;
  logic [ADDR_W-1:0]    rs2_addr;
  logic [WORD_SIZE-1:0] rs1_data;
  logic [WORD_SIZE-1:0] rs2_data;
  logic [WORD_SIZE-1:0] wb_data;
  logic                 wb_fwd_en;
  logic [ADDR_W-1:0]    wb_fwd_rd;
  logic [WORD_SIZE-1:0] output_port;
  logic [WORD_SIZE-1:0] num_inst;

  modport master (
    output wb_valid, mem_data, alu_result, rd, mem_to_reg, reg_write, is_wwd,
    output rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_data, wb_fwd_en, wb_fwd_rd, output_port, num_inst
  );

  modport slave (
    input  wb_valid, mem_data, alu_result, rd, mem_to_reg, reg_write, is_wwd,
    input  rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_data, wb_fwd_en, wb_fwd_rd, output_port, num_inst
  );
endinterface

// File: rtl/wb_regfile_stage.sv
// -----------------------------------------------------------------------------
// wb_regfile_stage
//   Write-back end of the MEM/WB pipeline boundary. Selects the write-back
//   value, commits it to a small register file, latches the WWD output port
//   and counts retired instructions. ID-stage reads see a same-cycle write
//   through a write-through bypass.
// Ports
//   clk      : rising-edge clock
//   reset_n  : asynchronous, active-low reset (clears regs, output_port, num_inst)
//   bus      : wb_regfile_stage_if.slave (see interface file for signal list)
// -----------------------------------------------------------------------------
module wb_regfile_stage #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_REGS  = 4,
  parameter int ADDR_W    = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  wb_regfile_stage_if.slave  bus
);

  logic [WORD_SIZE-1:0] r_regs [NUM_REGS];
  logic [WORD_SIZE-1:0] r_output_port;
  logic [WORD_SIZE-1:0] r_num_inst;

  logic [WORD_SIZE-1:0] w_wb_data;
  logic                 w_wr_en;
  logic                 w_byp1;
  logic                 w_byp2;

  assign w_wb_data = bus.mem_to_reg ? bus.mem_data : bus.alu_result;

  // Gating with wb_valid first keeps a bubble's don't-care (possibly X)
  // controls from leaking into the bypass or forwarding outputs.
  assign w_wr_en = bus.wb_valid && bus.reg_write;
  assign w_byp1  = w_wr_en && (bus.rs1_addr == bus.rd);
  assign w_byp2  = w_wr_en && (bus.rs2_addr == bus.rd);

  assign bus.wb_data     = w_wb_data;
  assign bus.wb_fwd_en   = w_wr_en;
  assign bus.wb_fwd_rd   = bus.rd;
  assign bus.rs1_data    = w_byp1 ? w_wb_data : r_regs[bus.rs1_addr];
  assign bus.rs2_data    = w_byp2 ? w_wb_data : r_regs[bus.rs2_addr];
  assign bus.output_port = r_output_port;
  assign bus.num_inst    = r_num_inst;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the register array is reset explicitly because software may read
      // any register before writing it and must see 0; this keeps it in flops
      // rather than a RAM macro, which is fine at this depth.
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_output_port <= '0;
      r_num_inst    <= '0;
    end else if (bus.wb_valid) begin
      // NOTE: non-blocking assignments so every update in this block uses the
      // pre-edge values, matching real flop behaviour.
      if (bus.reg_write) begin
        r_regs[bus.rd] <= w_wb_data;
      end
      if (bus.is_wwd) begin
        r_output_port <= bus.alu_result;
      end
      r_num_inst <= r_num_inst + 1'b1;  // wraps naturally at 2^WORD_SIZE
    end
  end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile_stage
//   Directed vectors for wb_regfile_stage. Stimulus pushes hand-computed
//   expected values into a scoreboard queue right after a rising edge; a
//   monitor drains and compares the queue on every falling edge.
// -----------------------------------------------------------------------------
module tb_wb_regfile_stage;

  typedef enum int {S_RS1, S_RS2, S_WB_DATA, S_FWD_EN, S_FWD_RD, S_OUT_PORT, S_NUM_INST} sel_e;

  typedef struct {
    string       name;
    sel_e        sel;
    logic [15:0] exp;
  } exp_t;

  logic clk;
  logic reset_n;
  exp_t sb_q[$];
  int   n_vectors;
  int   n_miscompares;

  wb_regfile_stage_if #(.WORD_SIZE(16), .ADDR_W(2)) bus ();

  wb_regfile_stage #(.WORD_SIZE(16), .NUM_REGS(4), .ADDR_W(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] actual(sel_e s);
    case (s)
      S_RS1:      return bus.rs1_data;
      S_RS2:      return bus.rs2_data;
      S_WB_DATA:  return bus.wb_data;
      S_FWD_EN:   return {15'd0, bus.wb_fwd_en};
      S_FWD_RD:   return {14'd0, bus.wb_fwd_rd};
      S_OUT_PORT: return bus.output_port;
      default:    return bus.num_inst;
    endcase
  endfunction

  // Monitor: compare every pending expectation on the falling edge.
  always @(negedge clk) begin
    while (sb_q.size() != 0) begin
      exp_t e;
      logic [15:0] a;
      e = sb_q.pop_front();
      a = actual(e.sel);
      n_vectors++;
      if (a !== e.exp) begin
        n_miscompares++;
        $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", e.name, a, e.exp, $time);
      end
    end
  end

  task automatic expect_val(input string name, input sel_e sel, input logic [15:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Drive one WB-stage cycle shortly after the rising edge.
  task automatic drive(input logic valid, input logic rw, input logic m2r, input logic wwd,
                       input logic [1:0] rd, input logic [15:0] mem, input logic [15:0] alu,
                       input logic [1:0] a1, input logic [1:0] a2);
    @(posedge clk);
    #1;
    bus.wb_valid   = valid;
    bus.reg_write  = rw;
    bus.mem_to_reg = m2r;
    bus.is_wwd     = wwd;
    bus.rd         = rd;
    bus.mem_data   = mem;
    bus.alu_result = alu;
    bus.rs1_addr   = a1;
    bus.rs2_addr   = a2;
  endtask

  task automatic read_regs(input logic [1:0] a1, input logic [1:0] a2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0, a1, a2);
  endtask

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    reset_n = 1'b0;
    bus.wb_valid = 1'b0; bus.reg_write = 1'b0; bus.mem_to_reg = 1'b0; bus.is_wwd = 1'b0;
    bus.rd = '0; bus.mem_data = '0; bus.alu_result = '0; bus.rs1_addr = '0; bus.rs2_addr = '0;

    // Reset state
    read_regs(2'd0, 2'd3);
    expect_val("reset_rs1",  S_RS1, 16'h0);
    expect_val("reset_rs2",  S_RS2, 16'h0);
    expect_val("reset_port", S_OUT_PORT, 16'h0);
    expect_val("reset_cnt",  S_NUM_INST, 16'h0);
    @(negedge clk);
    #1 reset_n = 1'b1;

    // ALU write to r2 with same-cycle bypass
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 16'h0000, 16'h1234, 2'd2, 2'd0);
    expect_val("alu_byp_rs1", S_RS1, 16'h1234);
    expect_val("alu_rs2_r0",  S_RS2, 16'h0000);
    expect_val("alu_wb_data", S_WB_DATA, 16'h1234);
    expect_val("alu_fwd_en",  S_FWD_EN, 16'h1);
    expect_val("alu_fwd_rd",  S_FWD_RD, 16'h2);
    expect_val("alu_cnt_pre", S_NUM_INST, 16'h0);
    read_regs(2'd2, 2'd2);
    expect_val("alu_rs1_post", S_RS1, 16'h1234);
    expect_val("alu_rs2_post", S_RS2, 16'h1234);
    expect_val("alu_fwd_off",  S_FWD_EN, 16'h0);
    expect_val("alu_cnt_post", S_NUM_INST, 16'h1);

    // Load write to r3
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 16'hBEEF, 16'h0001, 2'd3, 2'd2);
    expect_val("ld_wb_data", S_WB_DATA, 16'hBEEF);
    expect_val("ld_byp_rs1", S_RS1, 16'hBEEF);
    expect_val("ld_rs2_r2",  S_RS2, 16'h1234);
    read_regs(2'd3, 2'd1);
    expect_val("ld_rs1_post", S_RS1, 16'hBEEF);
    expect_val("ld_rs2_r1",   S_RS2, 16'h0000);
    expect_val("ld_cnt",      S_NUM_INST, 16'h2);

    // WWD without a register write
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 16'h0000, 16'h00A5, 2'd1, 2'd3);
    expect_val("wwd_no_byp",   S_RS1, 16'h0000);
    expect_val("wwd_fwd_en",   S_FWD_EN, 16'h0);
    expect_val("wwd_port_pre", S_OUT_PORT, 16'h0000);
    read_regs(2'd1, 2'd3);
    expect_val("wwd_port",  S_OUT_PORT, 16'h00A5);
    expect_val("wwd_r1",    S_RS1, 16'h0000);
    expect_val("wwd_r3",    S_RS2, 16'hBEEF);
    expect_val("wwd_cnt",   S_NUM_INST, 16'h3);

    // Register write and WWD together, both ports bypassed, r0 writable
    drive(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 16'h0000, 16'h5A5A, 2'd0, 2'd0);
    expect_val("both_byp_rs1", S_RS1, 16'h5A5A);
    expect_val("both_byp_rs2", S_RS2, 16'h5A5A);
    read_regs(2'd0, 2'd2);
    expect_val("both_r0",   S_RS1, 16'h5A5A);
    expect_val("both_r2",   S_RS2, 16'h1234);
    expect_val("both_port", S_OUT_PORT, 16'h5A5A);
    expect_val("both_cnt",  S_NUM_INST, 16'h4);

    // Bubble with write controls asserted and unknown data
    drive(1'b0, 1'b1, 1'bx, 1'bx, 2'd1, 16'hxxxx, 16'hxxxx, 2'd1, 2'd0);
    expect_val("bub_no_byp", S_RS1, 16'h0000);
    expect_val("bub_rs2",    S_RS2, 16'h5A5A);
    expect_val("bub_fwd_en", S_FWD_EN, 16'h0);
    read_regs(2'd1, 2'd0);
    expect_val("bub_r1_kept", S_RS1, 16'h0000);
    expect_val("bub_cnt",     S_NUM_INST, 16'h4);
    expect_val("bub_port",    S_OUT_PORT, 16'h5A5A);

    // Asynchronous reset asserted mid-cycle, checked before any clock edge
    read_regs(2'd2, 2'd3);
    #2 reset_n = 1'b0;
    expect_val("arst_r2",   S_RS1, 16'h0000);
    expect_val("arst_r3",   S_RS2, 16'h0000);
    expect_val("arst_port", S_OUT_PORT, 16'h0000);
    expect_val("arst_cnt",  S_NUM_INST, 16'h0000);
    @(negedge clk);
    #1 reset_n = 1'b1;

    // Counter wrap: 65536 retirements return num_inst to 0
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 2'd0, 2'd0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 2'd0, 2'd0);
    expect_val("wrap_ffff", S_NUM_INST, 16'hFFFF);
    read_regs(2'd0, 2'd1);
    expect_val("wrap_zero", S_NUM_INST, 16'h0000);
    expect_val("wrap_r0",   S_RS1, 16'h0000);

    // Bounded drain of the scoreboard
    repeat (3) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_vectors++;
      n_miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
